// File: rtl/alu_arbiter_if.sv
// Bundle of request and response signals between two requesters, the
// consumer and the arbitrated ALU block.
//
// Handshake: a transfer happens on a rising clk edge where both valid and
// ready are 1. A source that raises valid keeps valid and its payload
// unchanged until that edge; ready may depend combinationally on valid.
interface alu_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [3:0]  req0_op;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  logic        req1_valid;
  logic        req1_ready;
  logic [3:0]  req1_op;
  logic [31:0] req1_a;
  logic [31:0] req1_b;
  logic        resp_valid;
  logic        resp_ready;
  logic        resp_id;
  logic [31:0] resp_out;
  logic        resp_zero;
  logic        resp_equal;
  logic        resp_err;
  logic [1:0]  state_dbg;

  // Requesters and consumer side.
  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output resp_ready,
    input  req0_ready, req1_ready,
    input  resp_valid, resp_id, resp_out, resp_zero, resp_equal, resp_err,
    input  state_dbg
  );

  // Arbiter side.
  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  resp_ready,
    output req0_ready, req1_ready,
    output resp_valid, resp_id, resp_out, resp_zero, resp_equal, resp_err,
    output state_dbg
  );
endinterface

// File: rtl/alu_arbiter.sv
// Shared 32-bit ALU and a two-requester round-robin front end.
// Each request goes IDLE -> EXEC -> RESP; the ALU only ever sees the
// latched operand registers, so requester inputs can change freely
// once they have been accepted.

// Combinational team ALU; illegal op codes give out=0 and err=1.
module alu (
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] out,
  output logic        zero,
  output logic        equal,
  output logic        err
);
  // Op decode and result selection.
  always_comb begin
    out = '0;
    err = 1'b0;
    case (op)
      4'b0001: out = a & b;
      4'b0010: out = a | b;
      4'b0011: out = a ^ b;
      4'b0101: out = a << b[4:0];
      4'b0110: out = a >> b[4:0];
      4'b0111: out = $signed(a) >>> b[4:0];
      4'b1000: out = a + b;
      4'b1100: out = a - b;
      4'b1101: out = {31'd0, $signed(a) < $signed(b)};
      4'b1111: out = {31'd0, a < b};
      default: err = 1'b1;
    endcase
  end

  assign zero  = (out == 32'd0);
  assign equal = (a == b);
endmodule

module alu_arbiter (
  input  logic         clk,
  input  logic         rst,
  alu_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_q;
  state_t      state_d;

  logic        any_valid;
  logic        grant_id;
  logic        accept;
  logic        ready0;
  logic        ready1;
  logic        resp_valid_c;

  // Last granted requester; reset to 1 so requester 0 wins the first tie.
  logic        last_grant_q;

  logic [3:0]  op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic        id_q;

  logic [31:0] out_q;
  logic        zero_q;
  logic        equal_q;
  logic        err_q;

  logic [31:0] alu_out;
  logic        alu_zero;
  logic        alu_equal;
  logic        alu_err;

  assign any_valid = bus.req0_valid | bus.req1_valid;

  alu u_alu (
    .op    (op_q),
    .a     (a_q),
    .b     (b_q),
    .out   (alu_out),
    .zero  (alu_zero),
    .equal (alu_equal),
    .err   (alu_err)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_valid) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (bus.resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: round-robin grant, ready strobes and response valid.
  always_comb begin
    grant_id = bus.req1_valid;
    if (bus.req0_valid && bus.req1_valid) begin
      grant_id = ~last_grant_q;
    end
    // Gating with rst keeps both readies low during a reset cycle.
    accept       = (state_q == IDLE) && rst && any_valid;
    ready0       = accept && !grant_id;
    ready1       = accept && grant_id;
    resp_valid_c = (state_q == RESP);
  end

  // Operand capture at acceptance, plus arbitration history.
  always_ff @(posedge clk) begin
    if (!rst) begin
      op_q         <= 4'd0;
      a_q          <= 32'd0;
      b_q          <= 32'd0;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
    end else if (accept) begin
      op_q         <= grant_id ? bus.req1_op : bus.req0_op;
      a_q          <= grant_id ? bus.req1_a  : bus.req0_a;
      b_q          <= grant_id ? bus.req1_b  : bus.req0_b;
      id_q         <= grant_id;
      last_grant_q <= grant_id;
    end
  end

  // Result capture during the single EXEC cycle; held through RESP.
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_q   <= 32'd0;
      zero_q  <= 1'b0;
      equal_q <= 1'b0;
      err_q   <= 1'b0;
    end else if (state_q == EXEC) begin
      out_q   <= alu_out;
      zero_q  <= alu_zero;
      equal_q <= alu_equal;
      err_q   <= alu_err;
    end
  end

  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;
  assign bus.resp_valid = resp_valid_c;
  assign bus.resp_id    = id_q;
  assign bus.resp_out   = out_q;
  assign bus.resp_zero  = zero_q;
  assign bus.resp_equal = equal_q;
  assign bus.resp_err   = err_q;
  assign bus.state_dbg  = state_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed scenarios plus a randomized two-requester stream for alu_arbiter.
module tb_alu_arbiter;
  logic clk;
  logic rst;
  int   tests;
  int   fails;

  alu_arbiter_if bus ();

  alu_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // {resp_valid, resp_id, resp_out, resp_zero, resp_equal, resp_err}
  logic [36:0] resp_vec;
  assign resp_vec = {bus.resp_valid, bus.resp_id, bus.resp_out,
                     bus.resp_zero, bus.resp_equal, bus.resp_err};

  logic [35:0] exp_q[$];

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  // Reference ALU from the op-code table: returns {out, zero, equal, err}.
  function automatic logic [34:0] ref_alu(input logic [3:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    logic [31:0]        r;
    logic               e;
    logic signed [31:0] sa;
    int                 sh;
    r  = 32'd0;
    e  = 1'b0;
    sa = a;
    sh = int'(b[4:0]);
    if      (op == 4'b0001) r = a & b;
    else if (op == 4'b0010) r = a | b;
    else if (op == 4'b0011) r = a ^ b;
    else if (op == 4'b0101) r = a << sh;
    else if (op == 4'b0110) r = a >> sh;
    else if (op == 4'b0111) r = sa >>> sh;
    else if (op == 4'b1000) r = a + b;
    else if (op == 4'b1100) r = a + ~b + 32'd1;
    else if (op == 4'b1101) r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
    else if (op == 4'b1111) r = (a < b) ? 32'd1 : 32'd0;
    else e = 1'b1;
    return {r, (r == 32'd0), (a == b), e};
  endfunction

  // Driver tasks.
  task automatic idle_inputs();
    bus.req0_valid = 1'b0; bus.req0_op = 4'd0; bus.req0_a = 32'd0; bus.req0_b = 32'd0;
    bus.req1_valid = 1'b0; bus.req1_op = 4'd0; bus.req1_a = 32'd0; bus.req1_b = 32'd0;
    bus.resp_ready = 1'b0;
  endtask

  task automatic drive_req(input int id, input logic [3:0] op,
                           input logic [31:0] a, input logic [31:0] b);
    if (id == 0) begin
      bus.req0_op = op; bus.req0_a = a; bus.req0_b = b; bus.req0_valid = 1'b1;
    end else begin
      bus.req1_op = op; bus.req1_a = a; bus.req1_b = b; bus.req1_valid = 1'b1;
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    idle_inputs();
    next_cycle();
    next_cycle();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle_inputs();
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    bus.resp_ready = 1'b1;
    @(negedge clk);
    tests++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin
      fails++; $display("FAIL reset_ready: got %b want 00", {bus.req0_ready, bus.req1_ready});
    end
    next_cycle();
    @(negedge clk);
    tests++;
    if (resp_vec !== 37'd0) begin
      fails++; $display("FAIL reset_outputs: got %h want 0", resp_vec);
    end
    tests++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin
      fails++; $display("FAIL reset_ready_held: got %b want 00", {bus.req0_ready, bus.req1_ready});
    end
    next_cycle();
    idle_inputs();
    rst = 1'b1;
  endtask

  task automatic test_add();
    apply_reset();
    bus.resp_ready = 1'b1;
    drive_req(0, 4'b1000, 32'd5, 32'd7);
    @(negedge clk);
    tests++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
      fails++; $display("FAIL add_grant: got %b want 10", {bus.req0_ready, bus.req1_ready});
    end
    next_cycle();
    bus.req0_valid = 1'b0;
    @(negedge clk);
    tests++;
    if ({bus.req0_ready, bus.req1_ready, bus.resp_valid} !== 3'b000) begin
      fails++; $display("FAIL add_exec: got %b want 000", {bus.req0_ready, bus.req1_ready, bus.resp_valid});
    end
    next_cycle();
    @(negedge clk);
    tests++;
    if (resp_vec !== {1'b1, 1'b0, 32'd12, 3'b000}) begin
      fails++; $display("FAIL add_resp: got %h want %h", resp_vec, {1'b1, 1'b0, 32'd12, 3'b000});
    end
    next_cycle();
    @(negedge clk);
    tests++;
    if (bus.resp_valid !== 1'b0) begin
      fails++; $display("FAIL add_idle: got %b want 0", bus.resp_valid);
    end
  endtask

  task automatic test_round_robin();
    logic [32:0] seen[$];
    bit done0;
    bit done1;
    done0 = 1'b0;
    done1 = 1'b0;
    apply_reset();
    bus.resp_ready = 1'b1;
    drive_req(0, 4'b1100, 32'd3, 32'd5);
    drive_req(1, 4'b1101, 32'hFFFF_FFFF, 32'd1);
    for (int c = 0; c < 30 && seen.size() < 2; c++) begin
      @(negedge clk);
      tests++;
      if (bus.req0_ready && bus.req1_ready) begin
        fails++; $display("FAIL rr_both_ready: got 11 want not both");
      end
      if (bus.req0_ready) done0 = 1'b1;
      if (bus.req1_ready) done1 = 1'b1;
      if (bus.resp_valid && bus.resp_ready) seen.push_back({bus.resp_id, bus.resp_out});
      next_cycle();
      if (done0) bus.req0_valid = 1'b0;
      if (done1) bus.req1_valid = 1'b0;
    end
    tests++;
    if (seen.size() != 2) begin
      fails++; $display("FAIL rr_count: got %0d want 2", seen.size());
    end else begin
      tests++;
      if (seen[0] !== {1'b0, 32'hFFFF_FFFE}) begin
        fails++; $display("FAIL rr_first: got %h want %h", seen[0], {1'b0, 32'hFFFF_FFFE});
      end
      tests++;
      if (seen[1] !== {1'b1, 32'd1}) begin
        fails++; $display("FAIL rr_second: got %h want %h", seen[1], {1'b1, 32'd1});
      end
    end
    drive_req(0, 4'b1000, 32'd1, 32'd1);
    drive_req(1, 4'b1000, 32'd2, 32'd2);
    @(negedge clk);
    tests++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
      fails++; $display("FAIL rr_alternate: got %b want 10", {bus.req0_ready, bus.req1_ready});
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    bus.resp_ready = 1'b0;
    drive_req(1, 4'b0011, 32'hA5A5_A5A5, 32'hA5A5_A5A5);
    @(negedge clk);
    tests++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b01) begin
      fails++; $display("FAIL bp_grant: got %b want 01", {bus.req0_ready, bus.req1_ready});
    end
    next_cycle();
    bus.req1_valid = 1'b0;
    drive_req(0, 4'b1000, 32'd9, 32'd9);
    @(negedge clk);
    tests++;
    if ({bus.req0_ready, bus.req1_ready, bus.resp_valid} !== 3'b000) begin
      fails++; $display("FAIL bp_exec: got %b want 000", {bus.req0_ready, bus.req1_ready, bus.resp_valid});
    end
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      if (i == 4) bus.resp_ready = 1'b1;
      @(negedge clk);
      tests++;
      if (resp_vec !== {1'b1, 1'b1, 32'd0, 3'b110}) begin
        fails++; $display("FAIL bp_hold%0d: got %h want %h", i, resp_vec, {1'b1, 1'b1, 32'd0, 3'b110});
      end
      tests++;
      if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin
        fails++; $display("FAIL bp_no_grant%0d: got %b want 00", i, {bus.req0_ready, bus.req1_ready});
      end
    end
    next_cycle();
    bus.resp_ready = 1'b0;
    @(negedge clk);
    tests++;
    if ({bus.req0_ready, bus.req1_ready, bus.resp_valid} !== 3'b100) begin
      fails++; $display("FAIL bp_after: got %b want 100", {bus.req0_ready, bus.req1_ready, bus.resp_valid});
    end
  endtask

  task automatic test_illegal();
    apply_reset();
    bus.resp_ready = 1'b1;
    drive_req(0, 4'b0000, 32'd3, 32'd3);
    @(negedge clk);
    tests++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
      fails++; $display("FAIL ill_grant: got %b want 10", {bus.req0_ready, bus.req1_ready});
    end
    next_cycle();
    bus.req0_valid = 1'b0;
    next_cycle();
    @(negedge clk);
    tests++;
    if (resp_vec !== {1'b1, 1'b0, 32'd0, 3'b111}) begin
      fails++; $display("FAIL ill_resp: got %h want %h", resp_vec, {1'b1, 1'b0, 32'd0, 3'b111});
    end
    next_cycle();
    drive_req(0, 4'b0010, 32'h0000_00F0, 32'h0000_000F);
    @(negedge clk);
    tests++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
      fails++; $display("FAIL ill_next_grant: got %b want 10", {bus.req0_ready, bus.req1_ready});
    end
    next_cycle();
    bus.req0_valid = 1'b0;
    next_cycle();
    @(negedge clk);
    tests++;
    if (resp_vec !== {1'b1, 1'b0, 32'h0000_00FF, 3'b000}) begin
      fails++; $display("FAIL ill_next_resp: got %h want %h", resp_vec, {1'b1, 1'b0, 32'h0000_00FF, 3'b000});
    end
  endtask

  task automatic test_reset_in_exec();
    bit saw_valid;
    saw_valid = 1'b0;
    apply_reset();
    bus.resp_ready = 1'b1;
    drive_req(0, 4'b0111, 32'h8000_0000, 32'd4);
    @(negedge clk);
    tests++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
      fails++; $display("FAIL rx_grant: got %b want 10", {bus.req0_ready, bus.req1_ready});
    end
    next_cycle();
    bus.req0_valid = 1'b0;
    rst = 1'b0;
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if (resp_vec !== 37'd0) begin
      fails++; $display("FAIL rx_outputs: got %h want 0", resp_vec);
    end
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      @(negedge clk);
      if (bus.resp_valid !== 1'b0) saw_valid = 1'b1;
    end
    tests++;
    if (saw_valid) begin
      fails++; $display("FAIL rx_no_resp: got resp_valid 1 want 0");
    end
    next_cycle();
    drive_req(0, 4'b1000, 32'd1, 32'd2);
    drive_req(1, 4'b1000, 32'd3, 32'd4);
    @(negedge clk);
    tests++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
      fails++; $display("FAIL rx_tie: got %b want 10", {bus.req0_ready, bus.req1_ready});
    end
  endtask

  task automatic test_random();
    logic [3:0]  legal_ops [10];
    logic [3:0]  p_op [2];
    logic [31:0] p_a [2];
    logic [31:0] p_b [2];
    bit          taken [2];
    int          phase;
    logic        last;
    logic        g;
    logic [1:0]  exp_r;
    logic [34:0] r;
    int          acc;
    int          rsp;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    legal_ops = '{4'b0001, 4'b0010, 4'b0011, 4'b0101, 4'b0110,
                  4'b0111, 4'b1000, 4'b1100, 4'b1101, 4'b1111};
    apply_reset();
    exp_q.delete();
    phase = 0;
    last  = 1'b1;
    acc   = 0;
    rsp   = 0;
    for (int c = 0; c < 700; c++) begin
      @(negedge clk);
      exp_r = 2'b00;
      g     = 1'b0;
      if (phase == 0 && (bus.req0_valid || bus.req1_valid)) begin
        g     = (bus.req0_valid && bus.req1_valid) ? ~last : bus.req1_valid;
        exp_r = g ? 2'b01 : 2'b10;
      end
      tests++;
      if ({bus.req0_ready, bus.req1_ready} !== exp_r) begin
        fails++; $display("FAIL rnd_ready c%0d: got %b want %b", c, {bus.req0_ready, bus.req1_ready}, exp_r);
      end
      tests++;
      if (bus.resp_valid !== (phase == 2)) begin
        fails++; $display("FAIL rnd_valid c%0d: got %b want %b", c, bus.resp_valid, (phase == 2));
      end
      if (phase == 2 && exp_q.size() > 0) begin
        tests++;
        if (resp_vec[35:0] !== exp_q[0]) begin
          fails++; $display("FAIL rnd_resp c%0d: got %h want %h", c, resp_vec[35:0], exp_q[0]);
        end
      end
      taken[0] = 1'b0;
      taken[1] = 1'b0;
      if (exp_r != 2'b00) begin
        r = ref_alu(p_op[g], p_a[g], p_b[g]);
        exp_q.push_back({g, r});
        last     = g;
        taken[g] = 1'b1;
        acc++;
        phase = 1;
      end else if (phase == 1) begin
        phase = 2;
      end else if (phase == 2 && bus.resp_ready) begin
        void'(exp_q.pop_front());
        rsp++;
        phase = 0;
      end
      next_cycle();
      if (taken[0]) bus.req0_valid = 1'b0;
      if (taken[1]) bus.req1_valid = 1'b0;
      for (int id = 0; id < 2; id++) begin
        if (((id == 0) ? bus.req0_valid : bus.req1_valid) == 1'b0 &&
            c < 550 && $urandom_range(0, 2) == 0) begin
          op = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15))
                                           : legal_ops[$urandom_range(0, 9)];
          a  = $urandom;
          b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
          if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 40));
          p_op[id] = op;
          p_a[id]  = a;
          p_b[id]  = b;
          drive_req(id, op, a, b);
        end
      end
      bus.resp_ready = ($urandom_range(0, 3) != 0);
    end
    tests++;
    if (acc != rsp || exp_q.size() != 0 || acc < 20) begin
      fails++; $display("FAIL rnd_totals: got acc=%0d rsp=%0d left=%0d want equal, none left, acc>=20",
                        acc, rsp, exp_q.size());
    end
  endtask

  // Test sequence.
  initial begin
    tests = 0;
    fails = 0;
    rst   = 1'b0;
    idle_inputs();
    test_reset();
    test_add();
    test_round_robin();
    test_backpressure();
    test_illegal();
    test_reset_in_exec();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
